// File: rtl/display_seq.sv
// display_seq: walks a bank of 2x2 result groups one element at a time
// towards a ready/valid display sink.
//
// A snapshot of results_i is taken when run_display is first seen in IDLE,
// and again when the last element is accepted in loop mode. Only the snapshot
// is ever shown. Each accepted element is followed by HOLD_CYC idle gap cycles
// (HOLD), during which the last element stays on the bus with valid low.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   run_display         high while the controller is in its display state
//   loop_mode           1 = wrap and repeat with a fresh snapshot, 0 = one-shot
//   results_i           flat bus, element k = grp*4+pos at [k*DATA_W +: DATA_W]
//   display_ready_i     sink accepts the current element
//   display_result_o    current element value
//   display_valid_o     display_result_o is valid
//   display_grp_o       group index of the current element (k/4)
//   display_pos_o       position within the group (k%4: c11,c12,c21,c22)
//   state_display_o     FSM state: IDLE=0, SHOW=1, HOLD=2, DONE=3
//   done_o              high throughout DONE
module display_seq #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_GRP  = 3,
  parameter  int HOLD_CYC = 2,
  localparam int GRP_W    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run_display,
  input  logic                        loop_mode,
  input  logic [NUM_GRP*4*DATA_W-1:0] results_i,
  input  logic                        display_ready_i,
  output logic [DATA_W-1:0]           display_result_o,
  output logic                        display_valid_o,
  output logic [GRP_W-1:0]            display_grp_o,
  output logic [1:0]                  display_pos_o,
  output logic [2:0]                  state_display_o,
  output logic                        done_o
);

  localparam int N_EL  = NUM_GRP * 4;
  localparam int K_W   = $clog2(N_EL);
  localparam int BUS_W = N_EL * DATA_W;
  localparam int HC_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_EL - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SHOW = 3'd1,
    S_HOLD = 3'd2,
    S_DONE = 3'd3
  } state_t;

  // After an accepted element: gap state if a gap is configured, else straight on.
  localparam state_t S_AFTER = (HOLD_CYC > 0) ? S_HOLD : S_SHOW;

  state_t              r_state, w_state;
  logic [K_W-1:0]      r_k, w_k;
  logic [HC_W-1:0]     r_hold, w_hold;
  logic [BUS_W-1:0]    r_snap, w_snap;
  logic [DATA_W-1:0]   r_result, w_result;
  logic [GRP_W-1:0]    r_grp, w_grp;
  logic [1:0]          r_pos, w_pos;
  logic                r_valid, w_valid;
  logic                r_done, w_done;

  function automatic logic [DATA_W-1:0] f_elem(input logic [BUS_W-1:0] bus,
                                               input logic [K_W-1:0]   k);
    f_elem = bus[k*DATA_W +: DATA_W];
  endfunction

  // Next-state, index, gap counter, snapshot and next output values.
  always_comb begin
    w_state  = r_state;
    w_k      = r_k;
    w_hold   = r_hold;
    w_snap   = r_snap;
    w_valid  = 1'b0;
    w_done   = 1'b0;
    w_result = '0;
    w_grp    = '0;
    w_pos    = 2'd0;

    case (r_state)
      S_IDLE: begin
        w_k    = '0;
        w_hold = '0;
        if (run_display) begin
          w_snap  = results_i;
          w_state = S_SHOW;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_SHOW: begin
        // Abort wins over a simultaneous transfer: the element is not counted.
        if (!run_display) begin
          w_state = S_IDLE;
          w_k     = '0;
          w_hold  = '0;
        end else if (display_ready_i) begin
          w_hold = '0;
          if (r_k == K_LAST) begin
            if (loop_mode) begin
              // The index already points at element 0 of the new snapshot;
              // the gap still shows the element just accepted.
              w_snap  = results_i;
              w_k     = '0;
              w_state = S_AFTER;
            end else begin
              w_state = S_DONE;
            end
          end else begin
            w_k     = r_k + K_W'(1);
            w_state = S_AFTER;
          end
        end else begin
          w_state = S_SHOW;
        end
      end
      S_HOLD: begin
        if (!run_display) begin
          w_state = S_IDLE;
          w_k     = '0;
          w_hold  = '0;
        end else if (r_hold == HC_LAST) begin
          w_state = S_SHOW;
          w_hold  = '0;
        end else begin
          w_hold = r_hold + HC_W'(1);
        end
      end
      S_DONE: begin
        if (!run_display) begin
          w_state = S_IDLE;
          w_k     = '0;
        end else begin
          w_state = S_DONE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_k     = '0;
        w_hold  = '0;
      end
    endcase

    // Outputs are computed for the state being entered so they can be registered.
    case (w_state)
      S_SHOW: begin
        w_valid  = 1'b1;
        w_result = f_elem(w_snap, w_k);
        w_grp    = GRP_W'(w_k >> 2);
        w_pos    = w_k[1:0];
      end
      S_HOLD: begin
        w_result = r_result;
        w_grp    = r_grp;
        w_pos    = r_pos;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_hold   <= '0;
      r_snap   <= '0;
      r_result <= '0;
      r_grp    <= '0;
      r_pos    <= 2'd0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_k      <= w_k;
      r_hold   <= w_hold;
      r_snap   <= w_snap;
      r_result <= w_result;
      r_grp    <= w_grp;
      r_pos    <= w_pos;
      r_valid  <= w_valid;
      r_done   <= w_done;
    end
  end

  assign display_result_o = r_result;
  assign display_valid_o  = r_valid;
  assign display_grp_o    = r_grp;
  assign display_pos_o    = r_pos;
  assign state_display_o  = r_state;
  assign done_o           = r_done;

endmodule

// File: tb/tb_display_seq.sv
module tb_display_seq;

  logic        clk = 1'b0;
  logic        reset, run, loop_m, ready, run0, ready0;
  logic [95:0] results;

  logic [7:0]  result_a, result_b;
  logic        valid_a, valid_b, done_a, done_b;
  logic [1:0]  grp_a, grp_b, pos_a, pos_b;
  logic [2:0]  state_a, state_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_seq u_dut (
    .clk(clk), .reset(reset), .run_display(run), .loop_mode(loop_m),
    .results_i(results), .display_ready_i(ready),
    .display_result_o(result_a), .display_valid_o(valid_a),
    .display_grp_o(grp_a), .display_pos_o(pos_a),
    .state_display_o(state_a), .done_o(done_a)
  );

  display_seq #(.HOLD_CYC(0)) u_dut0 (
    .clk(clk), .reset(reset), .run_display(run0), .loop_mode(loop_m),
    .results_i(results), .display_ready_i(ready0),
    .display_result_o(result_b), .display_valid_o(valid_b),
    .display_grp_o(grp_b), .display_pos_o(pos_b),
    .state_display_o(state_b), .done_o(done_b)
  );

  typedef struct {
    logic       run;
    logic       ready;
    logic       v;
    logic [7:0] r;
    logic [1:0] g;
    logic [1:0] p;
    logic [2:0] s;
    logic       d;
    bit         cd;
  } vec_t;

  vec_t tbl[37];
  int   got[$];

  function automatic logic [95:0] fill(input int base);
    logic [95:0] b;
    b = '0;
    for (int k = 0; k < 12; k++) b[k*8 +: 8] = 8'(k + base);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input bit sel, input logic ev,
                       input logic [7:0] er, input logic [1:0] eg,
                       input logic [1:0] ep, input logic [2:0] es,
                       input logic ed, input bit cd);
    logic av, ad;
    logic [7:0] ar;
    logic [1:0] ag, ap;
    logic [2:0] as;
    if (sel) begin
      av = valid_b; ar = result_b; ag = grp_b; ap = pos_b; as = state_b; ad = done_b;
    end else begin
      av = valid_a; ar = result_a; ag = grp_a; ap = pos_a; as = state_a; ad = done_a;
    end
    n_checks++;
    if (av !== ev || as !== es || ad !== ed ||
        (cd && (ar !== er || ag !== eg || ap !== ep))) begin
      n_fail++;
      $display("FAIL %s: got v=%0d r=%0d g=%0d p=%0d s=%0d d=%0d, want v=%0d r=%0d g=%0d p=%0d s=%0d d=%0d",
               nm, av, ar, ag, ap, as, ad, ev, er, eg, ep, es, ed);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default-parameter timeline: element every 3 cycles, DONE afterwards.
    for (int j = 0; j < 34; j++) begin
      int e;
      e = j / 3;
      tbl[j].run = 1'b1; tbl[j].ready = 1'b1;
      tbl[j].v   = (j % 3 == 0);
      tbl[j].r   = 8'(e + 1);
      tbl[j].g   = 2'(e / 4);
      tbl[j].p   = 2'(e % 4);
      tbl[j].s   = (j % 3 == 0) ? 3'd1 : 3'd2;
      tbl[j].d   = 1'b0;
      tbl[j].cd  = 1'b1;
    end
    for (int j = 34; j < 37; j++) begin
      tbl[j].run = (j < 36); tbl[j].ready = 1'b1;
      tbl[j].v = 1'b0; tbl[j].r = 8'd0; tbl[j].g = 2'd0; tbl[j].p = 2'd0;
      tbl[j].s = (j < 36) ? 3'd3 : 3'd0;
      tbl[j].d = (j < 36);
      tbl[j].cd = (j == 36);
    end

    reset = 1'b1; run = 1'b0; loop_m = 1'b0; ready = 1'b1;
    run0 = 1'b0; ready0 = 1'b1; results = fill(1);
    tick(); tick();
    check("reset_a", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    check("reset_b", 1'b1, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    check("idle_a", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);

    // Table-driven default sequence.
    for (int j = 0; j < 37; j++) begin
      run = tbl[j].run; ready = tbl[j].ready;
      tick();
      check($sformatf("seq_c%0d", j + 1), 1'b0, tbl[j].v, tbl[j].r, tbl[j].g,
            tbl[j].p, tbl[j].s, tbl[j].d, tbl[j].cd);
    end

    // No gap: twelve back-to-back elements, then DONE, then IDLE.
    run0 = 1'b1; ready0 = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      check($sformatf("b2b_%0d", j), 1'b1, 1'b1, 8'(j + 1), 2'(j / 4), 2'(j % 4), 3'd1, 1'b0, 1'b1);
    end
    tick();
    check("b2b_done", 1'b1, 1'b0, 8'd0, 2'd0, 2'd0, 3'd3, 1'b1, 1'b0);
    run0 = 1'b0;
    tick();
    check("b2b_idle", 1'b1, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);

    // Back-pressure on element 3.
    run = 1'b1; ready = 1'b1;
    repeat (10) tick();
    check("stall_pre", 1'b0, 1'b1, 8'd4, 2'd0, 2'd3, 3'd1, 1'b0, 1'b1);
    ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("stall_%0d", j), 1'b0, 1'b1, 8'd4, 2'd0, 2'd3, 3'd1, 1'b0, 1'b1);
    end
    ready = 1'b1;
    tick();
    check("stall_hold1", 1'b0, 1'b0, 8'd4, 2'd0, 2'd3, 3'd2, 1'b0, 1'b1);
    tick();
    check("stall_hold2", 1'b0, 1'b0, 8'd4, 2'd0, 2'd3, 3'd2, 1'b0, 1'b1);
    tick();
    check("stall_resume", 1'b0, 1'b1, 8'd5, 2'd1, 2'd0, 3'd1, 1'b0, 1'b1);
    // Abort during SHOW with ready high: abort wins.
    run = 1'b0;
    tick();
    check("abort_show", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    run = 1'b1;
    tick();
    check("restart1", 1'b0, 1'b1, 8'd1, 2'd0, 2'd0, 3'd1, 1'b0, 1'b1);

    // Abort in HOLD after element 6, then restart from element 0.
    repeat (19) tick();
    check("hold_e6", 1'b0, 1'b0, 8'd7, 2'd1, 2'd2, 3'd2, 1'b0, 1'b1);
    run = 1'b0;
    tick();
    check("abort_hold", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    run = 1'b1;
    tick();
    check("restart2", 1'b0, 1'b1, 8'd1, 2'd0, 2'd0, 3'd1, 1'b0, 1'b1);
    tick();
    check("restart2_h1", 1'b0, 1'b0, 8'd1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b1);
    tick();
    check("restart2_h2", 1'b0, 1'b0, 8'd1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b1);
    tick();
    check("restart2_e1", 1'b0, 1'b1, 8'd2, 2'd0, 2'd1, 3'd1, 1'b0, 1'b1);
    run = 1'b0;
    tick();

    // Loop mode with results changed during pass 1.
    loop_m = 1'b1; run = 1'b1; results = fill(1);
    got.delete();
    for (int c = 0; c < 120 && got.size() < 24; c++) begin
      tick();
      if (c == 5) results = fill(101);
      if (valid_a) got.push_back(int'(result_a));
    end
    check_int("loop_count", got.size(), 24);
    for (int i = 0; i < got.size() && i < 24; i++)
      check_int($sformatf("loop_%0d", i), got[i], (i < 12) ? i + 1 : i - 12 + 101);
    run = 1'b0; loop_m = 1'b0; results = fill(1);
    tick();
    check("loop_idle", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);

    // Reset in SHOW at element 8, then a fresh full run.
    run = 1'b1;
    repeat (25) tick();
    check("pre_reset_e8", 1'b0, 1'b1, 8'd9, 2'd2, 2'd0, 3'd1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    check("reset_show", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    reset = 1'b0;
    got.delete();
    for (int c = 0; c < 100 && !done_a; c++) begin
      tick();
      if (valid_a) got.push_back(int'(result_a));
    end
    check_int("fresh_count", got.size(), 12);
    for (int i = 0; i < got.size() && i < 12; i++)
      check_int($sformatf("fresh_%0d", i), got[i], i + 1);
    check("fresh_done", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd3, 1'b1, 1'b0);
    // Reset while in DONE.
    reset = 1'b1;
    tick();
    check("reset_done", 1'b0, 1'b0, 8'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    reset = 1'b0; run = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_seq.md
DISPLAY_SEQ -- requirements
Module: display_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, width of one result element.
REQ-002 The block SHALL have parameter NUM_GRP, default 3, number of 2x2 result groups (PE, 3x3, 2x2).
REQ-003 The block SHALL have parameter HOLD_CYC, default 2, gap cycles after each accepted element; 0 legal.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk  input  1  rising-edge clock.
REQ-006 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port run_display  input  1  high while the controller is in S_DISPLAY.
REQ-008 The block SHALL have port loop_mode  input  1  1 = wrap and repeat; 0 = one-shot.
REQ-009 The block SHALL have port results_i  input  NUM_GRP*4*DATA_W  flat result bus; element k = grp*4+pos occupies bits [(k+1)*DATA_W-1 : k*DATA_W]; pos 0..3 = c11,c12,c21,c22.
REQ-010 The block SHALL have port display_ready_i  input  1  sink accepts the current element.
REQ-011 The block SHALL have port display_result_o  output  DATA_W  current element value.
REQ-012 The block SHALL have port display_valid_o  output  1  display_result_o is valid.
REQ-013 The block SHALL have port display_grp_o  output  ceil(log2(NUM_GRP)), min 1  group index of the current element.
REQ-014 The block SHALL have port display_pos_o  output  2  position of the current element within its group.
REQ-015 The block SHALL have port state_display_o  output  3  FSM state: IDLE=0, SHOW=1, HOLD=2, DONE=3.
REQ-016 The block SHALL have port done_o  output  1  high throughout DONE.

Function
REQ-017 The FSM SHALL have states IDLE, SHOW, HOLD and DONE; codes 4-7 SHALL be unused and SHALL recover to IDLE.
REQ-018 In IDLE, with run_display=1 at an edge, the block SHALL snapshot all of results_i, set index k=0 and enter SHOW; display_valid_o SHALL rise 1 cycle after run_display is first sampled.
REQ-019 Outputs SHALL come from the snapshot only; results_i changes after capture SHALL NOT affect the outputs until the next snapshot.
REQ-020 In SHOW, display_valid_o=1, display_result_o=element k, display_grp_o=k/4, display_pos_o=k%4; all outputs SHALL hold stable until a transfer occurs (valid & ready at an edge).
REQ-021 After a transfer with k not last and HOLD_CYC>0, the FSM SHALL enter HOLD for exactly HOLD_CYC cycles with valid=0 and result/grp/pos held, then return to SHOW with k+1.
REQ-022 After a transfer with HOLD_CYC=0, the block SHALL go directly SHOW->SHOW with k+1; valid stays high (back-to-back).
REQ-023 On transfer of the last element (k=NUM_GRP*4-1), the block SHALL sample loop_mode: 0 -> DONE; 1 -> take a fresh snapshot, set k=0 and follow REQ-021/022 as for a normal element.
REQ-024 DONE SHALL hold done_o=1 and valid=0 until run_display=0, then enter IDLE.
REQ-025 run_display=0 in SHOW or HOLD SHALL abort to IDLE at the next edge; the abort SHALL take priority over a simultaneous transfer, and that element SHALL NOT count as transferred.
REQ-026 In IDLE, display_result_o, display_grp_o, display_pos_o, valid and done_o SHALL all be 0.

Reset
REQ-027 reset=1 at an edge SHALL override all other inputs and force IDLE with every output 0 and the snapshot cleared; this SHALL hold mid-SHOW, mid-HOLD and in DONE.
REQ-028 After reset deasserts, the block SHALL behave per REQ-018 with no residual index or hold count.

Verification
REQ-029 Defaults, results_i element k = k+1, ready=1, loop=0, run at edge 0 -> valid in cycles 1,4,...,34 carrying 1..12; grp/pos follow 0/0..2/3; done_o from cycle 35; IDLE 1 cycle after run drops.
REQ-030 HOLD_CYC=0, ready=1 -> 12 consecutive valid cycles carrying 1..12, then DONE.
REQ-031 ready low for 5 cycles while showing element 3 (value 4) -> output stable at 4, grp 0, pos 3 throughout; the sequence resumes at 5 once ready rises.
REQ-032 loop=1, results_i changed to k+101 during pass 1 -> pass 1 shows 1..12; pass 2 shows 101..112.
REQ-033 run_display dropped while in HOLD after element 6, then raised again -> IDLE next edge with outputs 0; restart shows element 0 first.
REQ-034 reset pulsed in SHOW at element 8 -> all outputs 0 and state_display_o=0 next cycle; a fresh run shows 1..12.
